// File: rtl/btb_pkg.sv
// Shared BTB geometry, entry layout and PC field extraction.
// Fetch-side tag compare uses the same helpers so both sides agree on the PC split.
`ifndef PREFETCH_DISTANCE
`define PREFETCH_DISTANCE 1
`endif

package btb_pkg;
  localparam int BTB_ADDR     = 32;
  localparam int BTB_SETS     = 16;
  localparam int BTB_WAYS     = 2;
  localparam int BTB_TAG_BITS = 10;
  localparam int BTB_RD_PORTS = `PREFETCH_DISTANCE * 2;

  localparam int LS       = $clog2(BTB_SETS);
  localparam int AGE_BITS = $clog2(BTB_WAYS);

  typedef struct packed {
    logic                    valid;
    logic [BTB_TAG_BITS-1:0] tag;
    logic [BTB_ADDR-1:0]     target;
  } btb_entry_t;

  // pc[1:0] never takes part in indexing or tagging
  function automatic logic [LS-1:0] btb_index(input logic [BTB_ADDR-1:0] pc);
    return pc[LS+1:2];
  endfunction

  function automatic logic [BTB_TAG_BITS-1:0] btb_tag(input logic [BTB_ADDR-1:0] pc);
    return pc[LS+BTB_TAG_BITS+1:LS+2];
  endfunction
endpackage

// File: rtl/btb_if.sv
// Fetch lookups plus execute/retire update and invalidate requests.
interface btb_if
  import btb_pkg::*;
#(
  parameter int RD_PORTS = BTB_RD_PORTS,
  parameter int ADDR     = BTB_ADDR
);
  logic [RD_PORTS-1:0][ADDR-1:0] rd_pc;
  logic [RD_PORTS-1:0]           rd_hit;
  logic [RD_PORTS-1:0][ADDR-1:0] rd_target;
  logic                          wr_en;
  logic [ADDR-1:0]               wr_pc;
  logic [ADDR-1:0]               wr_target;
  logic                          inv_en;
  logic [ADDR-1:0]               inv_pc;

  modport master (output rd_pc, wr_en, wr_pc, wr_target, inv_en, inv_pc,
                  input  rd_hit, rd_target);
  modport slave  (input  rd_pc, wr_en, wr_pc, wr_target, inv_en, inv_pc,
                  output rd_hit, rd_target);
endinterface

// File: rtl/btb_lru_set.sv
// True-LRU age counters for one set; age 0 is MRU, the way at age WAYS-1 is the victim.
module btb_lru_set #(
  parameter int WAYS = 2,
  parameter int WW   = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          touch,
  input  logic [WW-1:0] touch_way,
  output logic [WW-1:0] victim
);
  if (WAYS > 1) begin : g_lru
    logic [WAYS-1:0][WW-1:0] age;

    // Ways younger than the touched one age by one, keeping ages a permutation
    always_ff @(posedge clock) begin
      if (reset) begin
        for (int w = 0; w < WAYS; w++) age[w] <= WW'(w);
      end else if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WW'(w) == touch_way)         age[w] <= '0;
          else if (age[w] < age[touch_way]) age[w] <= age[w] + WW'(1);
        end
      end
    end

    always_comb begin
      victim = '0;
      for (int w = 0; w < WAYS; w++)
        if (age[w] == WW'(WAYS - 1)) victim = WW'(w);
    end
  end else begin : g_dm
    assign victim = '0;
  end
endmodule

// File: rtl/btb_assoc.sv
// Set-associative BTB: combinational multi-port lookup, one write and one invalidate per cycle.
module btb_assoc
  import btb_pkg::*;
#(
  parameter int SETS     = BTB_SETS,
  parameter int WAYS     = BTB_WAYS,
  parameter int TAG_BITS = BTB_TAG_BITS,
  parameter int RD_PORTS = BTB_RD_PORTS
) (
  input logic  clock,
  input logic  reset,
  btb_if.slave bus
);
  localparam int WW = (WAYS > 1) ? $clog2(WAYS) : 1;
  typedef logic [WW-1:0] way_t;

  btb_entry_t              mem [SETS][WAYS];
  logic [SETS-1:0][WW-1:0] victim;

  logic [LS-1:0]       widx, iidx;
  logic [TAG_BITS-1:0] wtag, itag;
  logic                w_hit, w_free, i_hit, wr_do;
  way_t                w_hway, w_fway, w_way, i_way;

  assign widx = btb_index(bus.wr_pc);
  assign wtag = btb_tag(bus.wr_pc);
  assign iidx = btb_index(bus.inv_pc);
  assign itag = btb_tag(bus.inv_pc);

  // Lookups only see registered state; no forwarding from this cycle's wr/inv
  always_comb begin
    bus.rd_hit    = '0;
    bus.rd_target = '0;
    for (int p = 0; p < RD_PORTS; p++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (!reset && mem[btb_index(bus.rd_pc[p])][w].valid &&
            mem[btb_index(bus.rd_pc[p])][w].tag == btb_tag(bus.rd_pc[p])) begin
          bus.rd_hit[p]    = 1'b1;
          bus.rd_target[p] = mem[btb_index(bus.rd_pc[p])][w].target;
        end
      end
    end
  end

  // Descending scan so the lowest-index invalid way wins
  always_comb begin
    w_hit  = 1'b0;
    w_hway = '0;
    w_free = 1'b0;
    w_fway = '0;
    i_hit  = 1'b0;
    i_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (mem[widx][w].valid && mem[widx][w].tag == wtag) begin
        w_hit  = 1'b1;
        w_hway = way_t'(w);
      end
      if (!mem[widx][w].valid) begin
        w_free = 1'b1;
        w_fway = way_t'(w);
      end
      if (mem[iidx][w].valid && mem[iidx][w].tag == itag) begin
        i_hit = 1'b1;
        i_way = way_t'(w);
      end
    end
    w_way = w_hit ? w_hway : (w_free ? w_fway : victim[widx]);
    wr_do = bus.wr_en && !(bus.inv_en && iidx == widx && itag == wtag);
  end

  // Write lands after the invalidate so a write reusing the invalidated way keeps its entry
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) mem[s][w] <= '0;
    end else begin
      if (bus.inv_en && i_hit) mem[iidx][i_way].valid <= 1'b0;
      if (wr_do) mem[widx][w_way] <= '{valid: 1'b1, tag: wtag, target: bus.wr_target};
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_set
    btb_lru_set #(.WAYS(WAYS), .WW(WW)) u_lru (
      .clock    (clock),
      .reset    (reset),
      .touch    (wr_do && widx == LS'(s)),
      .touch_way(w_way),
      .victim   (victim[s])
    );
  end
endmodule

// File: doc/btb_assoc.md
Name: btb_assoc

Overview:
- Set-associative branch target buffer; successor of the direct-mapped BTB in the fetch stage.
- Serves RD_PORTS parallel lookups per cycle for the prefetch window.
- Accepts one resolved-branch update and one invalidate per cycle from the execute/retire path.
- Adds per-entry valid bits (zero targets are legal), configurable ways, true-LRU replacement and explicit invalidation.

Parameters:
- SETS, 16, number of sets; power of two, at least 2.
- WAYS, 2, associativity; power of two, 1 to 8.
- TAG_BITS, 10, stored tag width.
- RD_PORTS, `PREFETCH_DISTANCE*2, parallel lookup ports.

Ports:
- clock  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- rd_pc  in  RD_PORTS x ADDR  lookup PCs.
- rd_hit  out  RD_PORTS  lookup hit per port.
- rd_target  out  RD_PORTS x ADDR  predicted target; '0 when no hit.
- wr_en  in  1  install or update an entry.
- wr_pc  in  ADDR  branch PC to write.
- wr_target  in  ADDR  resolved target.
- inv_en  in  1  invalidate the entry matching inv_pc.
- inv_pc  in  ADDR  PC to invalidate.

Behaviour:
- Address split, with LS = log2(SETS):
  - index = pc[LS+1:2]
  - tag = pc[LS+TAG_BITS+1:LS+2]
  - pc[1:0] is ignored.
- Entry contents: valid, tag, target. Each set also holds one age counter per way, log2(WAYS) bits wide (0 = MRU).
- Lookup is combinational, zero latency:
  - rd_hit[i] = 1 iff some way in set index(rd_pc[i]) is valid with a matching tag.
  - rd_target[i] = that way's target, otherwise '0.
  - Lookups see registered state only. There is no same-cycle forwarding from wr or inv.
- Lookups never modify LRU state.
- While reset is high, all rd_hit = 0 and all rd_target = '0.
- Write (wr_en=1), applied at the next posedge:
  - Tag hit in the set: overwrite that way's target.
  - Tag miss: allocate the lowest-index invalid way. If no way is invalid, allocate the way with the maximum age (LRU).
  - The written way gets valid=1, tag and target set, age set to 0.
  - Every way in the set whose age was below the written way's old age increments by 1. Ages stay a permutation of 0..WAYS-1.
- Invalidate (inv_en=1), applied at the next posedge:
  - A tag hit clears that way's valid bit. Ages are unchanged, so an invalid way is reused first by the invalid-first rule.
  - A miss has no effect.
- Simultaneous wr_en and inv_en:
  - Different sets: both apply.
  - Same set and same tag: the invalidate wins. The entry ends invalid, the write is dropped and ages are unchanged.
  - Same set, different tags: both apply. Write allocation is computed on pre-invalidate state.
- Reset: all valid bits = 0, tags and targets = '0, and age of way w = w in every set. It takes effect at the first posedge with reset high. Reset mid-operation discards any pending write or invalidate in that cycle.
- WAYS=1 degenerates to direct-mapped with valid bits. The age field is zero-width and handled with a generate guard.

Decomposition:
- btb_pkg holds:
  - the btb_entry_t struct {valid, tag, target}
  - the localparams LS and AGE_BITS
  - functions btb_index() and btb_tag(), shared with the fetch-side tag compare.
- Sub-module btb_lru_set (one instance per set): holds the WAYS age counters. It takes a touch enable plus way number and outputs the victim way. It lets the LRU logic be verified standalone.

Test Plan (SETS=16, WAYS=2, TAG_BITS=10):
- After reset, rd_pc=0x40 → rd_hit=0, rd_target=0. Write wr_pc=0x40, wr_target=0x0 → the next cycle rd_hit=1, rd_target=0x0 (zero target valid).
- Write 0x40→0x100, then 0x440→0x200 (same set 0, different tag) → both hit. Write 0x840→0x300 → 0x40 (LRU, way 0) is evicted, while 0x440 and 0x840 hit.
- Fill set 0 with 0x40 and 0x440, rewrite 0x40→0x111 (touch), then write 0x840 → 0x440 is evicted and 0x40 hits with 0x111.
- inv_en with inv_pc=0x440, then write 0x840 → allocated into the invalidated way, and 0x40 is retained.
- Same cycle wr_en with wr_pc=0x40 and inv_en with inv_pc=0x40 on a resident entry → the next cycle rd_hit=0. Same cycle write of 0x44 (set 1) → only 0x44 hits.
- Same-cycle read of 0x40 during its install → rd_hit=0 that cycle and 1 the next. Assert reset with a write pending → all rd_hit=0 for every port afterwards.
